// File: rtl/sr_driver.sv
// SR latch write driver: handshake in, a clean S or R pulse out, Q/Qn feedback confirmation with timeout.
// Optional statistics counters are enabled by defining SR_DRV_STATS_EN.
module sr_driver #(
    parameter int PULSE_W = 2,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    input  logic q_fb,
    input  logic qn_fb,
    output logic S,
    output logic R,
    output logic en,
    output logic busy,
    output logic done,
    output logic err
`ifdef SR_DRV_STATS_EN
    ,
    output logic [15:0] set_cnt,
    output logic [15:0] rst_cnt,
    output logic [15:0] err_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, PULSE, WAIT, DONE, ERR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             val, val_nxt;
    logic             s_nxt, r_nxt, en_nxt, busy_nxt, done_nxt, err_nxt, ready_nxt;
    logic             set_inc, rst_inc, err_inc;
    logic             match, acc_match;

    // q_fb == qn_fb can never satisfy either comparison pair, so it never counts as a match
    assign match     = (q_fb == val) && (qn_fb != val);
    assign acc_match = (q_fb == req_val) && (qn_fb != req_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            val       <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            val       <= val_nxt;
            S         <= s_nxt;
            R         <= r_nxt;
            en        <= en_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            req_ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        val_nxt   = val;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        en_nxt    = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        ready_nxt = req_ready;
        set_inc   = 1'b0;
        rst_inc   = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                if (req_valid && req_ready) begin
                    val_nxt   = req_val;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    if (acc_match) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = PULSE;
                        en_nxt    = 1'b1;
                        s_nxt     = req_val;
                        r_nxt     = !req_val;
                        set_inc   = req_val;
                        rst_inc   = !req_val;
                    end
                end
            end
            PULSE: begin
                if (cnt == CNT_W'(PULSE_W - 1)) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end else begin
                    en_nxt  = 1'b1;
                    s_nxt   = val;
                    r_nxt   = !val;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                if (match) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                    err_inc   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                // A skipped write arrives here with done low and spends one cycle raising it
                if (done) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                end else begin
                    done_nxt = 1'b1;
                end
            end
            ERR: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
            end
        endcase
    end

`ifdef SR_DRV_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            set_cnt <= '0;
            rst_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (set_inc && set_cnt != 16'hFFFF) set_cnt <= set_cnt + 16'd1;
            if (rst_inc && rst_cnt != 16'hFFFF) rst_cnt <= rst_cnt + 16'd1;
            if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = set_inc ^ rst_inc ^ err_inc;
`endif

endmodule
